// File: rtl/hazard_stall_ctrl.sv
// Stall/flush sequencer: turns hazard and memory-wait requests into per-stage enables, flushes and bubbles.
// Latency: controls are Mealy (same cycle as the request); counters and timeout update on the next clk_i edge.
module hazard_stall_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned TIMEOUT      = 64,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             load_use_i,
    input  logic             mem_busy_i,
    input  logic             branch_taken_i,
    output logic             pc_en_o,
    output logic             ifid_en_o,
    output logic             ifid_flush_o,
    output logic             idex_en_o,
    output logic             idex_flush_o,
    output logic             exmem_en_o,
    output logic             memwb_bubble_o,
    output logic             busy_o,
    output logic             timeout_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT);
    localparam logic [2:0]        SH_INIT  = 3'(FLUSH_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_MEM_WAIT,
        ST_FLUSH
    } state_t;

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [2:0]        shadow_q, shadow_d;
    logic [CNT_W-1:0]  stall_cnt_q, flush_cnt_q;
    logic              timeout_q;
    logic              freeze;
    logic              flush_ev;
    logic              stall_ev;
    logic              timeout_hit;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= ST_RUN;
            wait_q      <= '0;
            shadow_q    <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            wait_q   <= wait_d;
            shadow_q <= shadow_d;
            if (stall_ev && (stall_cnt_q != CNT_MAX)) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            if (flush_ev && (flush_cnt_q != CNT_MAX)) begin
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            end
            if (timeout_hit) begin
                timeout_q <= 1'b1;
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        wait_d         = wait_q;
        shadow_d       = shadow_q;
        freeze         = 1'b0;
        flush_ev       = 1'b0;
        pc_en_o        = 1'b1;
        ifid_en_o      = 1'b1;
        ifid_flush_o   = 1'b0;
        idex_en_o      = 1'b1;
        idex_flush_o   = 1'b0;
        exmem_en_o     = 1'b1;
        memwb_bubble_o = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (mem_busy_i) begin
                    freeze  = 1'b1;
                    state_d = ST_MEM_WAIT;
                    wait_d  = WAIT_W'(1);
                end else if (branch_taken_i) begin
                    ifid_flush_o = 1'b1;
                    idex_flush_o = 1'b1;
                    flush_ev     = 1'b1;
                    if (FLUSH_CYCLES > 0) begin
                        state_d  = ST_FLUSH;
                        shadow_d = SH_INIT;
                    end
                end else if (load_use_i) begin
                    pc_en_o      = 1'b0;
                    ifid_en_o    = 1'b0;
                    idex_flush_o = 1'b1;
                end
            end

            ST_MEM_WAIT: begin
                // The release cycle is still frozen and still counts toward the timeout.
                freeze = 1'b1;
                if (wait_q != WAIT_MAX) begin
                    wait_d = wait_q + WAIT_W'(1);
                end
                if (!mem_busy_i) begin
                    state_d = ST_RUN;
                end
            end

            ST_FLUSH: begin
                if (mem_busy_i) begin
                    freeze   = 1'b1;
                    state_d  = ST_MEM_WAIT;
                    wait_d   = WAIT_W'(1);
                    shadow_d = '0;
                end else if (branch_taken_i) begin
                    // A fresh taken branch must also squash the instruction now in ID.
                    ifid_flush_o = 1'b1;
                    idex_flush_o = 1'b1;
                    flush_ev     = 1'b1;
                    shadow_d     = SH_INIT;
                end else begin
                    ifid_flush_o = 1'b1;
                    if (shadow_q <= 3'd1) begin
                        state_d  = ST_RUN;
                        shadow_d = '0;
                    end else begin
                        shadow_d = shadow_q - 3'd1;
                    end
                end
            end

            default: begin
                state_d  = ST_RUN;
                shadow_d = '0;
            end
        endcase

        if (freeze) begin
            pc_en_o        = 1'b0;
            ifid_en_o      = 1'b0;
            idex_en_o      = 1'b0;
            exmem_en_o     = 1'b0;
            memwb_bubble_o = 1'b1;
        end

        // Reset must release every stall control immediately, whatever the requests say.
        if (!rst_n_i) begin
            pc_en_o        = 1'b1;
            ifid_en_o      = 1'b1;
            ifid_flush_o   = 1'b0;
            idex_en_o      = 1'b1;
            idex_flush_o   = 1'b0;
            exmem_en_o     = 1'b1;
            memwb_bubble_o = 1'b0;
            flush_ev       = 1'b0;
            freeze         = 1'b0;
        end
    end

    assign stall_ev    = ~pc_en_o;
    assign timeout_hit = freeze && (wait_d == WAIT_MAX);

    assign busy_o      = (state_q != ST_RUN);
    assign timeout_o   = timeout_q;
    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: three parameterisations driven in lockstep, each scored against a behavioural model.
module tb_hazard_stall_ctrl;

    localparam int P_FC [3] = '{2, 0, 1};
    localparam int P_TO [3] = '{4, 64, 8};
    localparam int P_CW [3] = '{4, 16, 8};

    logic clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic rst_n_i = 1'b0;
    logic load_use_i = 1'b0;
    logic mem_busy_i = 1'b0;
    logic branch_taken_i = 1'b0;

    logic [2:0]  pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_bubble, busy, timeout;
    logic [3:0]  sc0, fc0;
    logic [15:0] sc1, fc1;
    logic [7:0]  sc2, fc2;

    hazard_stall_ctrl #(.FLUSH_CYCLES(P_FC[0]), .TIMEOUT(P_TO[0]), .CNT_W(P_CW[0])) u0 (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .load_use_i(load_use_i), .mem_busy_i(mem_busy_i),
        .branch_taken_i(branch_taken_i), .pc_en_o(pc_en[0]), .ifid_en_o(ifid_en[0]),
        .ifid_flush_o(ifid_flush[0]), .idex_en_o(idex_en[0]), .idex_flush_o(idex_flush[0]),
        .exmem_en_o(exmem_en[0]), .memwb_bubble_o(memwb_bubble[0]), .busy_o(busy[0]),
        .timeout_o(timeout[0]), .stall_cnt_o(sc0), .flush_cnt_o(fc0));

    hazard_stall_ctrl #(.FLUSH_CYCLES(P_FC[1]), .TIMEOUT(P_TO[1]), .CNT_W(P_CW[1])) u1 (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .load_use_i(load_use_i), .mem_busy_i(mem_busy_i),
        .branch_taken_i(branch_taken_i), .pc_en_o(pc_en[1]), .ifid_en_o(ifid_en[1]),
        .ifid_flush_o(ifid_flush[1]), .idex_en_o(idex_en[1]), .idex_flush_o(idex_flush[1]),
        .exmem_en_o(exmem_en[1]), .memwb_bubble_o(memwb_bubble[1]), .busy_o(busy[1]),
        .timeout_o(timeout[1]), .stall_cnt_o(sc1), .flush_cnt_o(fc1));

    hazard_stall_ctrl #(.FLUSH_CYCLES(P_FC[2]), .TIMEOUT(P_TO[2]), .CNT_W(P_CW[2])) u2 (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .load_use_i(load_use_i), .mem_busy_i(mem_busy_i),
        .branch_taken_i(branch_taken_i), .pc_en_o(pc_en[2]), .ifid_en_o(ifid_en[2]),
        .ifid_flush_o(ifid_flush[2]), .idex_en_o(idex_en[2]), .idex_flush_o(idex_flush[2]),
        .exmem_en_o(exmem_en[2]), .memwb_bubble_o(memwb_bubble[2]), .busy_o(busy[2]),
        .timeout_o(timeout[2]), .stall_cnt_o(sc2), .flush_cnt_o(fc2));

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    // Model: is a memory wait in progress, how long has it lasted, how many shadow cycles remain.
    bit m_wait   [3];
    int m_wlen   [3];
    int m_shadow [3];
    bit m_tmo    [3];
    int m_stall  [3];
    int m_flush  [3];

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %0d, expected %0d", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_wait[i] = 0; m_wlen[i] = 0; m_shadow[i] = 0;
            m_tmo[i] = 0; m_stall[i] = 0; m_flush[i] = 0;
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 3; i++) begin
            int  e_pc, e_ifen, e_iff, e_iden, e_idf, e_exen, e_bub, e_busy;
            int  cmax, g_sc, g_fc;
            bit  frz;
            string p;
            p    = $sformatf("u%0d.", i);
            cmax = (1 << P_CW[i]) - 1;
            if (!rst_n_i) begin
                m_wait[i] = 0; m_wlen[i] = 0; m_shadow[i] = 0;
                m_tmo[i] = 0; m_stall[i] = 0; m_flush[i] = 0;
            end
            e_pc = 1; e_ifen = 1; e_iff = 0; e_iden = 1; e_idf = 0; e_exen = 1; e_bub = 0;
            e_busy = (m_wait[i] || m_shadow[i] > 0) ? 1 : 0;
            frz = 0;
            if (rst_n_i) begin
                if (m_wait[i] || mem_busy_i) frz = 1;
                else if (branch_taken_i) begin e_iff = 1; e_idf = 1; end
                else if (m_shadow[i] > 0) e_iff = 1;
                else if (load_use_i) begin e_pc = 0; e_ifen = 0; e_idf = 1; end
                if (frz) begin e_pc = 0; e_ifen = 0; e_iden = 0; e_exen = 0; e_bub = 1; end
            end
            case (i)
                0:       begin g_sc = int'(sc0); g_fc = int'(fc0); end
                1:       begin g_sc = int'(sc1); g_fc = int'(fc1); end
                default: begin g_sc = int'(sc2); g_fc = int'(fc2); end
            endcase
            chk({p, "pc_en"},        int'(pc_en[i]),        e_pc);
            chk({p, "ifid_en"},      int'(ifid_en[i]),      e_ifen);
            chk({p, "ifid_flush"},   int'(ifid_flush[i]),   e_iff);
            chk({p, "idex_en"},      int'(idex_en[i]),      e_iden);
            chk({p, "idex_flush"},   int'(idex_flush[i]),   e_idf);
            chk({p, "exmem_en"},     int'(exmem_en[i]),     e_exen);
            chk({p, "memwb_bubble"}, int'(memwb_bubble[i]), e_bub);
            chk({p, "busy"},         int'(busy[i]),         e_busy);
            chk({p, "timeout"},      int'(timeout[i]),      int'(m_tmo[i]));
            chk({p, "stall_cnt"},    g_sc,                  m_stall[i]);
            chk({p, "flush_cnt"},    g_fc,                  m_flush[i]);
            if (rst_n_i) begin
                if (frz) begin
                    if (m_wait[i]) begin
                        if (m_wlen[i] < P_TO[i]) m_wlen[i]++;
                        if (!mem_busy_i) m_wait[i] = 0;
                    end else begin
                        m_wait[i] = 1; m_wlen[i] = 1; m_shadow[i] = 0;
                    end
                    if (m_wlen[i] >= P_TO[i]) m_tmo[i] = 1;
                end else if (branch_taken_i) begin
                    if (m_flush[i] < cmax) m_flush[i]++;
                    m_shadow[i] = P_FC[i];
                end else if (m_shadow[i] > 0) begin
                    m_shadow[i]--;
                end
                if (e_pc == 0 && m_stall[i] < cmax) m_stall[i]++;
            end
        end
    endtask

    task automatic step(input bit rst, input bit lu, input bit mb, input bit br);
        @(posedge clk_i);
        #1;
        rst_n_i = rst; load_use_i = lu; mem_busy_i = mb; branch_taken_i = br;
        @(negedge clk_i);
        check_all();
        cyc++;
    endtask

    initial begin
        int burst;
        model_reset();
        step(0, 0, 0, 0);
        step(0, 1, 1, 1);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        // single load-use
        step(1, 1, 0, 0);
        step(1, 0, 0, 0);
        // 5-cycle memory wait
        repeat (5) step(1, 0, 1, 0);
        repeat (2) step(1, 0, 0, 0);
        // long memory wait, timeout must stay sticky
        repeat (10) step(1, 0, 1, 0);
        repeat (3) step(1, 1, 0, 0);
        // branch beats load-use, shadow ignores load-use
        step(1, 1, 0, 1);
        repeat (2) step(1, 1, 0, 0);
        repeat (2) step(1, 0, 0, 0);
        // counter saturation from a clean reset
        step(0, 0, 0, 0);
        repeat (20) step(1, 1, 0, 0);
        step(1, 0, 0, 0);
        chk("u0.stall_sat", int'(sc0), 15);
        // memory wait in the middle of a flush shadow
        step(1, 0, 0, 1);
        repeat (2) step(1, 0, 1, 0);
        repeat (3) step(1, 0, 0, 0);
        // back-to-back branches restart the shadow
        step(1, 0, 0, 1);
        step(1, 0, 0, 1);
        repeat (3) step(1, 0, 0, 0);
        // reset mid-stall
        repeat (2) step(1, 0, 1, 0);
        step(0, 1, 1, 1);
        step(1, 0, 0, 0);

        burst = 0;
        repeat (3000) begin
            bit rst, lu, mb, br;
            rst = ($urandom_range(0, 199) != 0);
            if (burst > 0) begin
                mb = 1; burst--;
            end else if ($urandom_range(0, 99) < 6) begin
                mb = 1; burst = $urandom_range(0, 9);
            end else begin
                mb = 0;
            end
            br = ($urandom_range(0, 99) < 15);
            lu = ($urandom_range(0, 99) < 25);
            step(rst, lu, mb, br);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Consumer side of the pipeline hazard interface. Takes stall and flush requests and turns them into per-stage enable, flush and bubble controls for the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Adds sequential handling the hazard detector lacks:
  - multi-cycle data-memory wait freeze,
  - branch flush shadow,
  - memory-wait timeout flag,
  - saturating stall and flush performance counters.
- Sits between the hazard detector / data memory and the pipeline registers. It replaces the gated-clock stall scheme with synchronous enables.

Parameters:
- FLUSH_CYCLES, 1, extra cycles IF/ID stays flushed after a taken branch (fetch latency shadow). Range 0..7.
- TIMEOUT, 64, MEM_WAIT cycles before timeout_o sets. Must be ≥ 1.
- CNT_W, 16, width of the performance counters.

Ports:
- clk_i  in  1  pipeline clock.
- rst_n_i  in  1  asynchronous active-low reset.
- load_use_i  in  1  load-use hazard request from the hazard detector (combinational, same cycle).
- mem_busy_i  in  1  data memory not ready; the access in MEM must be held.
- branch_taken_i  in  1  taken branch or jump resolved in EX.
- pc_en_o  out  1  PC register write enable.
- ifid_en_o  out  1  IF/ID write enable.
- ifid_flush_o  out  1  IF/ID synchronous clear to NOP.
- idex_en_o  out  1  ID/EX write enable.
- idex_flush_o  out  1  ID/EX clear to NOP (bubble).
- exmem_en_o  out  1  EX/MEM write enable.
- memwb_bubble_o  out  1  MEM/WB loads a NOP.
- busy_o  out  1  state is not RUN.
- timeout_o  out  1  sticky: a memory wait exceeded TIMEOUT.
- stall_cnt_o  out  CNT_W  saturating count of cycles with pc_en_o=0.
- flush_cnt_o  out  CNT_W  saturating count of taken-branch flush events.

Behaviour:
- Reset (async, rst_n_i=0):
  - State RUN; internal counters 0.
  - timeout_o=0, stall_cnt_o=0, flush_cnt_o=0.
  - Combinational outputs take their RUN/no-request values: all enables 1, all flush and bubble outputs 0, busy_o=0.
- Outputs are Mealy: decoded from registered state plus the current inputs. Counters and timeout_o update on the clk_i rising edge.
- Request priority inside RUN: mem_busy_i > branch_taken_i > load_use_i.
- State RUN:
  - mem_busy_i=1: all enables 0 and memwb_bubble_o=1, same cycle. Next state MEM_WAIT; wait counter := 1.
  - else branch_taken_i=1: pc_en_o=1, ifid_flush_o=1, idex_flush_o=1, other enables 1. flush_cnt_o increments. Next state FLUSH when FLUSH_CYCLES>0 (shadow counter := FLUSH_CYCLES), otherwise stay RUN.
  - else load_use_i=1: pc_en_o=0, ifid_en_o=0, idex_flush_o=1, exmem_en_o=1. Stay RUN; the detector clears the request once the load advances.
  - else: normal flow.
- State MEM_WAIT:
  - All enables 0, memwb_bubble_o=1. branch_taken_i and load_use_i are ignored because the stages are frozen.
  - Wait counter increments each cycle, saturating at TIMEOUT. When it reaches TIMEOUT, timeout_o sets and stays set until reset.
  - mem_busy_i=0: this cycle is still frozen. Next state RUN; inputs are re-evaluated there.
- State FLUSH:
  - pc_en_o=1, ifid_flush_o=1, other enables 1, idex_flush_o=0.
  - Shadow counter decrements; at 1 the next state is RUN.
  - mem_busy_i=1 overrides: go to MEM_WAIT with the same outputs as RUN. The remaining shadow count is discarded.
  - A new branch_taken_i restarts the shadow at FLUSH_CYCLES and increments flush_cnt_o.
  - load_use_i is ignored.
- stall_cnt_o increments on every cycle where pc_en_o=0. Both counters saturate at all-ones and never wrap.
- busy_o = (state != RUN).
- Reset asserted mid-stall or mid-flush returns to RUN immediately and drops all stall controls asynchronously.

Test Plan:
- Reset with all inputs 0, released → enables all 1, flushes 0, counters 0, busy_o=0.
- load_use_i=1 for 1 cycle → that cycle pc_en_o=0, ifid_en_o=0, idex_flush_o=1; next cycle normal flow; stall_cnt_o=1.
- mem_busy_i=1 for 5 cycles, then 0 → RUN cycle plus 5 MEM_WAIT cycles frozen with memwb_bubble_o=1; stall_cnt_o=6; timeout_o=0.
- TIMEOUT=4, mem_busy_i held for 10 cycles → timeout_o=1 after the 4th cycle and stays 1 after mem_busy_i drops; cleared only by rst_n_i.
- FLUSH_CYCLES=2, branch_taken_i and load_use_i together → branch wins: pc_en_o=1 with ifid/idex flush; then 2 cycles of ifid_flush_o=1 only; flush_cnt_o=1; stall_cnt_o unchanged.
- Counter saturation with CNT_W=4 and 20 load-use cycles → stall_cnt_o=15. Mid-FLUSH mem_busy_i=1 → MEM_WAIT; on release returns to RUN with no residual flush.
